// File: rtl/uncache_axi_if.sv
// Single-beat AXI4 bus between the uncached-access master and the crossbar.
interface uncache_axi_if #(
    parameter int ADDR_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready
    );

    modport slave (
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );
endinterface

// File: rtl/uncache_axi_master.sv
// Uncached load/store engine: each request becomes one single-beat AXI4 transaction.
// Define UNCACHE_WBUF_EN to post writes through a one-entry write buffer.
module uncache_axi_master #(
    parameter logic [3:0] AXI_ID = 4'b0001,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [3:0]        req_wen,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    uncache_axi_if.master     bus
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [3:0]        wen;
    logic [31:0]       wdata;
    logic              aw_done;
    logic              w_done;
    logic              aw_fire;
    logic              w_fire;
    logic              write_stall;
    logic              unused_resp;

    assign aw_fire = (state == WR_AWW) && !aw_done && bus.awready;
    assign w_fire  = (state == WR_AWW) && !w_done && bus.wready;

`ifdef UNCACHE_WBUF_EN
    // The accepted write is still on the request bus the cycle after acceptance;
    // that cycle lets the CPU retire it, later requests wait for the buffer.
    logic posted_fresh;

    always_ff @(posedge clk) begin
        if (rst) posted_fresh <= 1'b0;
        else     posted_fresh <= (state == IDLE) && req_valid && (req_wen != 4'b0000);
    end

    assign write_stall = req_valid && !posted_fresh;
`else
    assign write_stall = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end
            if (state == RD_R && bus.rvalid) rdata <= bus.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            addr  <= req_addr;
            size  <= req_size;
            wen   <= req_wen;
            wdata <= req_wdata;
        end
    end

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = addr;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = {1'b0, size};
    assign bus.arburst = 2'b01;
    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = {1'b0, size};
    assign bus.awburst = 2'b01;
    assign bus.wdata   = wdata;
    assign bus.wstrb   = wen;
    assign bus.wlast   = 1'b1;

    // Responses are always completed regardless of ID or status.
    assign unused_resp = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) state_next = (req_wen == 4'b0000) ? RD_AR : WR_AWW;
            end
            RD_AR: begin
                stall       = 1'b1;
                bus.arvalid = 1'b1;
                if (bus.arready) state_next = RD_R;
            end
            RD_R: begin
                stall      = 1'b1;
                bus.rready = 1'b1;
                if (bus.rvalid) state_next = DONE;
            end
            WR_AWW: begin
                stall       = write_stall;
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_B;
            end
            WR_B: begin
                stall      = write_stall;
                bus.bready = 1'b1;
`ifdef UNCACHE_WBUF_EN
                if (bus.bvalid) state_next = IDLE;
`else
                if (bus.bvalid) state_next = DONE;
`endif
            end
            DONE: begin
                rdata_valid = (wen == 4'b0000);
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uncache_axi_master.sv
// Directed bench for uncache_axi_master; the bench drives the AXI slave side by hand.
module tb_uncache_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_wen;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uncache_axi_if #(.ADDR_W(32)) bus ();

    uncache_axi_master #(.AXI_ID(4'b0001), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus(bus)
    );

    task automatic slave_idle;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rid = 4'b0001;
        bus.rresp = 2'b00; bus.rlast = 1; bus.awready = 0; bus.wready = 0;
        bus.bvalid = 0; bus.bid = 4'b0001; bus.bresp = 2'b00;
    endtask

    task automatic drive_req(input logic [3:0] wen, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid = 1; req_wen = wen; req_size = sz; req_addr = a; req_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1; req_valid = 0; req_wen = 0; req_size = 0; req_addr = 0; req_wdata = 0;
        slave_idle();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin n_fail++; $display("FAIL reset_valids: got %b expected 00000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid: got %b expected 0", rdata_valid); end
        rst = 0;
    endtask

    task automatic test_read;
        @(negedge clk);
        drive_req(4'b0000, 2'd2, 32'h1FAF_F000, 32'h0);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rd_accept_stall: got %b expected 1", stall); end
        @(negedge clk); #1;
        n_checks++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL rd_arvalid: got %b expected 1", bus.arvalid); end
        n_checks++; if (bus.araddr !== 32'h1FAF_F000) begin n_fail++; $display("FAIL rd_araddr: got %h expected 1faff000", bus.araddr); end
        n_checks++; if ({bus.arsize, bus.arlen, bus.arburst} !== {3'd2, 8'd0, 2'b01}) begin n_fail++; $display("FAIL rd_ar_attr: got %h expected %h", {bus.arsize, bus.arlen, bus.arburst}, {3'd2, 8'd0, 2'b01}); end
        n_checks++; if (bus.arid !== 4'b0001) begin n_fail++; $display("FAIL rd_arid: got %h expected 1", bus.arid); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rd_stall_ar1: got %b expected 1", stall); end
        @(negedge clk); #1;
        n_checks++; if ({bus.arvalid, stall} !== 2'b11) begin n_fail++; $display("FAIL rd_ar_hold2: got %b expected 11", {bus.arvalid, stall}); end
        @(negedge clk); #1;
        n_checks++; if ({bus.arvalid, stall} !== 2'b11) begin n_fail++; $display("FAIL rd_ar_hold3: got %b expected 11", {bus.arvalid, stall}); end
        bus.arready = 1;
        @(negedge clk);
        bus.arready = 0; #1;
        n_checks++; if ({bus.arvalid, bus.rready, stall} !== 3'b011) begin n_fail++; $display("FAIL rd_r_phase: got %b expected 011", {bus.arvalid, bus.rready, stall}); end
        bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.rvalid = 0; bus.rdata = 32'h0; #1;
        n_checks++; if (rdata_valid !== 1'b1) begin n_fail++; $display("FAIL rd_done_valid: got %b expected 1", rdata_valid); end
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_done_data: got %h expected deadbeef", rdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rd_done_stall: got %b expected 0", stall); end
        req_valid = 0;
        @(negedge clk); #1;
        n_checks++; if ({rdata_valid, stall, bus.rready} !== 3'b000) begin n_fail++; $display("FAIL rd_after_idle: got %b expected 000", {rdata_valid, stall, bus.rready}); end
    endtask

`ifndef UNCACHE_WBUF_EN
    task automatic test_write_byte;
        @(negedge clk);
        drive_req(4'b0010, 2'd0, 32'h1FAF_F011, 32'h0000_AB00);
        @(negedge clk); #1;
        n_checks++; if ({bus.awvalid, bus.wvalid, stall} !== 3'b111) begin n_fail++; $display("FAIL wr_aww: got %b expected 111", {bus.awvalid, bus.wvalid, stall}); end
        n_checks++; if ({bus.awsize, bus.wstrb, bus.wlast} !== {3'd0, 4'b0010, 1'b1}) begin n_fail++; $display("FAIL wr_attr: got %h expected %h", {bus.awsize, bus.wstrb, bus.wlast}, {3'd0, 4'b0010, 1'b1}); end
        n_checks++; if ({bus.awaddr, bus.wdata} !== {32'h1FAF_F011, 32'h0000_AB00}) begin n_fail++; $display("FAIL wr_addr_data: got %h expected 1faff0110000ab00", {bus.awaddr, bus.wdata}); end
        bus.awready = 1; bus.wready = 1;
        @(negedge clk);
        bus.awready = 0; bus.wready = 0; #1;
        n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready, stall} !== 4'b0011) begin n_fail++; $display("FAIL wr_b_phase: got %b expected 0011", {bus.awvalid, bus.wvalid, bus.bready, stall}); end
        @(negedge clk); #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wr_b_wait_stall: got %b expected 1", stall); end
        bus.bvalid = 1;
        @(negedge clk);
        bus.bvalid = 0; #1;
        n_checks++; if ({stall, rdata_valid, bus.bready} !== 3'b000) begin n_fail++; $display("FAIL wr_done: got %b expected 000", {stall, rdata_valid, bus.bready}); end
        req_valid = 0;
    endtask

    task automatic test_write_wready_first;
        @(negedge clk);
        drive_req(4'b1111, 2'd2, 32'h1FAF_F020, 32'h1234_5678);
        @(negedge clk); #1;
        n_checks++; if ({bus.awvalid, bus.wvalid} !== 2'b11) begin n_fail++; $display("FAIL wf_both_valid: got %b expected 11", {bus.awvalid, bus.wvalid}); end
        bus.wready = 1;
        @(negedge clk);
        bus.wready = 0; #1;
        n_checks++; if ({bus.awvalid, bus.wvalid} !== 2'b10) begin n_fail++; $display("FAIL wf_w_dropped: got %b expected 10", {bus.awvalid, bus.wvalid}); end
        @(negedge clk); #1;
        n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b100) begin n_fail++; $display("FAIL wf_aw_held: got %b expected 100", {bus.awvalid, bus.wvalid, bus.bready}); end
        @(negedge clk); #1;
        n_checks++; if ({bus.awvalid, bus.bready, stall} !== 3'b101) begin n_fail++; $display("FAIL wf_aw_held2: got %b expected 101", {bus.awvalid, bus.bready, stall}); end
        bus.awready = 1;
        @(negedge clk);
        bus.awready = 0; #1;
        n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin n_fail++; $display("FAIL wf_b_phase: got %b expected 001", {bus.awvalid, bus.wvalid, bus.bready}); end
        bus.bvalid = 1;
        @(negedge clk);
        bus.bvalid = 0; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wf_done_stall: got %b expected 0", stall); end
        req_valid = 0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [2];
        logic [3:0]  wens [2];
        int          idx = 0;
        int          n_ar = 0, n_aw = 0, n_w = 0, n_rv = 0;
        logic        consumed = 0;
        logic [31:0] seen_rdata = '0, seen_araddr = '0, seen_awaddr = '0;
        addrs[0] = 32'h1FAF_F100; wens[0] = 4'b0000;
        addrs[1] = 32'h1FAF_F104; wens[1] = 4'b1111;
        bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        drive_req(wens[0], 2'd2, addrs[0], 32'h5555_AAAA);
        for (int cyc = 0; cyc < 40 && idx < 2; cyc++) begin
            if (consumed) begin
                idx++; consumed = 0;
                if (idx < 2) drive_req(wens[idx], 2'd2, addrs[idx], 32'h5555_AAAA);
                else req_valid = 0;
            end
            bus.arready = 1; bus.awready = 1; bus.wready = 1;
            bus.rvalid = bus.rready; bus.bvalid = bus.bready;
            #1;
            if (bus.arvalid && bus.arready) begin n_ar++; seen_araddr = bus.araddr; end
            if (bus.awvalid && bus.awready) begin n_aw++; seen_awaddr = bus.awaddr; end
            if (bus.wvalid && bus.wready) n_w++;
            if (rdata_valid) begin n_rv++; seen_rdata = rdata; end
            if (req_valid && !stall) consumed = 1;
            @(negedge clk);
        end
        slave_idle(); req_valid = 0;
        n_checks++; if (idx !== 2) begin n_fail++; $display("FAIL b2b_completed: got %0d expected 2", idx); end
        n_checks++; if (n_ar !== 1) begin n_fail++; $display("FAIL b2b_ar_count: got %0d expected 1", n_ar); end
        n_checks++; if (n_aw !== 1) begin n_fail++; $display("FAIL b2b_aw_count: got %0d expected 1", n_aw); end
        n_checks++; if (n_w !== 1) begin n_fail++; $display("FAIL b2b_w_count: got %0d expected 1", n_w); end
        n_checks++; if (n_rv !== 1) begin n_fail++; $display("FAIL b2b_rv_count: got %0d expected 1", n_rv); end
        n_checks++; if (seen_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_rdata: got %h expected cafef00d", seen_rdata); end
        n_checks++; if ({seen_araddr, seen_awaddr} !== {32'h1FAF_F100, 32'h1FAF_F104}) begin n_fail++; $display("FAIL b2b_addrs: got %h expected 1faff1001faff104", {seen_araddr, seen_awaddr}); end
    endtask
`else
    task automatic test_wbuf;
        @(negedge clk);
        drive_req(4'b1111, 2'd2, 32'h1FAF_F300, 32'hAABB_CCDD);
        @(negedge clk); #1;
        n_checks++; if ({stall, bus.awvalid, bus.wvalid} !== 3'b011) begin n_fail++; $display("FAIL wb_posted: got %b expected 011", {stall, bus.awvalid, bus.wvalid}); end
        @(negedge clk);
        drive_req(4'b0000, 2'd2, 32'h1FAF_F304, 32'h0); #1;
        n_checks++; if ({stall, bus.arvalid} !== 2'b10) begin n_fail++; $display("FAIL wb_rd_blocked_aww: got %b expected 10", {stall, bus.arvalid}); end
        bus.awready = 1; bus.wready = 1;
        @(negedge clk);
        bus.awready = 0; bus.wready = 0; #1;
        n_checks++; if ({stall, bus.arvalid, bus.bready} !== 3'b101) begin n_fail++; $display("FAIL wb_rd_blocked_b: got %b expected 101", {stall, bus.arvalid, bus.bready}); end
        bus.bvalid = 1;
        @(negedge clk);
        bus.bvalid = 0; #1;
        n_checks++; if ({stall, bus.arvalid, rdata_valid} !== 3'b100) begin n_fail++; $display("FAIL wb_idle_after_b: got %b expected 100", {stall, bus.arvalid, rdata_valid}); end
        @(negedge clk); #1;
        n_checks++; if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h1FAF_F304}) begin n_fail++; $display("FAIL wb_ar: got %h expected 11faff304", {bus.arvalid, bus.araddr}); end
        bus.arready = 1;
        @(negedge clk);
        bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h1122_3344;
        @(negedge clk);
        bus.rvalid = 0; #1;
        n_checks++; if ({rdata_valid, stall, rdata} !== {1'b1, 1'b0, 32'h1122_3344}) begin n_fail++; $display("FAIL wb_rd_done: got %h expected 211223344", {rdata_valid, stall, rdata}); end
        req_valid = 0;
    endtask
`endif

    task automatic test_reset_mid;
        logic        got = 0;
        logic [31:0] val = '0;
        @(negedge clk);
        drive_req(4'b0000, 2'd2, 32'h1FAF_F200, 32'h0);
        bus.arready = 1;
        @(negedge clk);
        @(negedge clk);
        bus.arready = 0; #1;
        n_checks++; if (bus.rready !== 1'b1) begin n_fail++; $display("FAIL rm_in_rd_r: got %b expected 1", bus.rready); end
        rst = 1; req_valid = 0;
        @(negedge clk); #1;
        n_checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, stall} !== 6'b0) begin n_fail++; $display("FAIL rm_valids_stall: got %b expected 000000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, stall}); end
        n_checks++; if ({rdata_valid, rdata} !== 33'h0) begin n_fail++; $display("FAIL rm_rdata: got %h expected 0", {rdata_valid, rdata}); end
        rst = 0;
        @(negedge clk);
        drive_req(4'b0000, 2'd2, 32'h1FAF_F208, 32'h0);
        bus.rdata = 32'h0BAD_F00D;
        for (int c = 0; c < 12 && !got; c++) begin
            bus.arready = 1; bus.rvalid = bus.rready;
            #1;
            if (rdata_valid) begin got = 1; val = rdata; end
            @(negedge clk);
        end
        slave_idle(); req_valid = 0;
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rm_reread_timeout: got %b expected 1", got); end
        n_checks++; if (val !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rm_reread_data: got %h expected 0badf00d", val); end
    endtask

    initial begin
        test_reset();
        test_read();
`ifdef UNCACHE_WBUF_EN
        test_wbuf();
`else
        test_write_byte();
        test_write_wready_first();
        test_back_to_back();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/uncache_axi_master.md
Name: uncache_axi_master

Overview:
- Consumer side of the address-translation path: takes uncached (kseg1-class) load/store requests already translated to physical address, with cache attribute 0.
- Performs each as a single-beat AXI4 transaction.
- Stalls the CPU memory stage until the access completes.
- Sits beside the cache miss path, ahead of the AXI crossbar/arbiter.

Parameters:
- AXI_ID, 4'b0001, fixed ID driven on arid/awid.
- ADDR_W, 32, physical address width.

Ports:
- clk in 1 — system clock.
- rst in 1 — synchronous active-high reset.
- req_valid in 1 — uncached request present; held stable while stall=1.
- req_wen in 4 — byte write enables; 4'b0000 = read.
- req_size in 2 — 0 byte, 1 half, 2 word.
- req_addr in ADDR_W — physical address.
- req_wdata in 32 — store data, byte-lane aligned.
- stall out 1 — CPU must hold the request.
- rdata out 32 — load data.
- rdata_valid out 1 — one-cycle pulse when rdata is valid.
- arid/araddr/arlen/arsize/arburst/arvalid out 4/ADDR_W/8/3/2/1; arready in 1.
- rid/rdata/rresp/rlast/rvalid in 4/32/2/1/1; rready out 1.
- awid/awaddr/awlen/awsize/awburst/awvalid out 4/ADDR_W/8/3/2/1; awready in 1.
- wdata/wstrb/wlast/wvalid out 32/4/1/1; wready in 1.
- bid/bresp/bvalid in 4/2/1; bready out 1.

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0; rdata 0; rdata_valid 0; stall 0.
- States: IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE.
- IDLE: req_valid=1 captures addr/size/wen/wdata into registers the same cycle. Next state is RD_AR if wen==0, else WR_AWW.
- stall (combinational) = (state==IDLE & req_valid) | (state not IDLE and not DONE).
- RD_AR: arvalid=1 until arready sampled high, then RD_R. Held values: araddr=captured addr, arsize={1'b0,size}, arlen=0, arburst=2'b01.
- RD_R: rready=1. On rvalid, rdata<=rdata_in and go to DONE.
- WR_AWW: awvalid and wvalid asserted together. Each drops independently after its own handshake, in either order or the same cycle. wlast=1, wstrb=captured wen, awsize as arsize. When both handshakes are done, go to WR_B.
- WR_B: bready=1. On bvalid, go to DONE.
- DONE: stall=0. rdata_valid=1 for reads only. Next cycle IDLE; no new request is accepted in DONE.
- Minimum latency, read: accept → arvalid next cycle → DONE one cycle after the rvalid handshake.
- rresp/bresp/rid/bid are ignored; the response is always completed.
- Valids never deassert before their handshake (AXI rule), except on rst.
- rst mid-transaction: immediate return to IDLE, all valids dropped; system-wide reset only.

Optional Feature:
- Macro: UNCACHE_WBUF_EN.
- Enabled — one-entry posted write buffer:
  - A write accepted in IDLE goes to WR_AWW, but stall is 0 from the cycle after acceptance.
  - After B completes, return directly to IDLE; no DONE state and no rdata_valid.
  - Any new request arriving while the buffer is busy stalls until B completes, then is accepted in IDLE.
- Disabled: writes stall until bvalid as described above.

Test Plan:
- Read word at 0x1FAF_F000, arready delayed 2 cycles, rdata=0xDEADBEEF one cycle later → araddr=0x1FAF_F000, arsize=2, arlen=0, stall=1 throughout, rdata_valid pulse with 0xDEADBEEF, stall=0 in that cycle.
- Byte store: wen=4'b0010, addr 0x1FAF_F011, wdata 0x0000AB00, size 0 → awsize=0, wstrb=0010, wlast=1; stall drops only in DONE after bvalid.
- Write with wready asserted 3 cycles before awready → wvalid drops after its handshake, awvalid held; WR_B entered only after awready.
- Read immediately followed by write (req_valid held, new request the cycle after DONE) → two clean transactions, no duplicate arvalid/awvalid.
- rst asserted while in RD_R → next cycle all valids 0, stall 0, rdata 0, state IDLE; a subsequent read completes normally.
- UNCACHE_WBUF_EN: write then read back-to-back → stall low after write accept; read stalls until bvalid; arvalid appears only after B completes.
